// File: rtl/execute_memory_register.sv
// Execute-to-memory pipeline register: 2-entry skid buffer (main M drives outputs,
// skid S absorbs one entry of backpressure), forwarding tap and saturating stall counter.
module execute_memory_register #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      wbs_in,
  input  logic                      mm_in,
  input  logic                      wm_in,
  input  logic                      wme_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_dest_in,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     store_data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      wbs_out,
  output logic                      mm_out,
  output logic                      wm_out,
  output logic                      wme_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_dest_out,
  output logic [DATA_WIDTH-1:0]     alu_result_out,
  output logic [DATA_WIDTH-1:0]     store_data_out,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_reg,
  output logic [DATA_WIDTH-1:0]     fwd_data,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  typedef struct packed {
    logic                      wbs;
    logic                      mm;
    logic                      wm;
    logic                      wme;
    logic [REG_ADDR_WIDTH-1:0] reg_dest;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     store_data;
  } entry_t;

  // Occupancy encodes the M/S valid bits; "S valid without M" has no encoding.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  entry_t m_q, s_q, in_entry;
  logic   accept;
  logic   load_m_in, load_m_skid, load_s;

  assign in_entry = '{wbs: wbs_in, mm: mm_in, wm: wm_in, wme: wme_in,
                      reg_dest: reg_dest_in, alu_result: alu_result_in,
                      store_data: store_data_in};

  assign in_ready  = (state != FULL);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state != EMPTY);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state and payload load selection; flush overrides everything
  always_comb begin
    state_nxt   = state;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_m_in = 1'b1;
          end
        end
        ONE: begin
          if (out_ready && accept) begin
            load_m_in = 1'b1;
          end else if (out_ready) begin
            state_nxt = EMPTY;
          end else if (accept) begin
            state_nxt = FULL;
            load_s    = 1'b1;
          end
        end
        FULL: begin
          if (out_ready) begin
            state_nxt   = ONE;
            load_m_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Payload storage; invalid entries keep their last data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m_in)        m_q <= in_entry;
      else if (load_m_skid) m_q <= s_q;
      if (load_s)           s_q <= in_entry;
    end
  end

  // Saturating count of cycles the memory stage refuses a valid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

  assign wbs_out        = m_q.wbs & out_valid;
  assign mm_out         = m_q.mm  & out_valid;
  assign wm_out         = m_q.wm  & out_valid;
  assign wme_out        = m_q.wme & out_valid;
  assign reg_dest_out   = m_q.reg_dest;
  assign alu_result_out = m_q.alu_result;
  assign store_data_out = m_q.store_data;

  assign fwd_valid = wbs_out;
  assign fwd_reg   = m_q.reg_dest;
  assign fwd_data  = m_q.alu_result;

endmodule

// File: doc/execute_memory_register.md
Name: execute_memory_register

Overview:
- Execute-to-memory pipeline stage register. It sits downstream of the decode/execute register and is the consumer of its outputs.
- It captures the ALU result, store data, destination register and memory/writeback controls from the execute stage, then presents them to the memory stage.
- A 2-entry skid buffer with valid/ready handshakes on both sides lets backpressure from the memory stage stall execute without losing data.
- It also provides a forwarding tap and a saturating stall-cycle counter for debug.

Parameters:
- DATA_WIDTH, 16, width of alu_result and store_data.
- REG_ADDR_WIDTH, 4, width of the destination register index.
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  execute stage presents a valid entry.
- in_ready  out  1  stage can accept an entry this cycle.
- wbs_in, mm_in, wm_in, wme_in  in  1 each  writeback-select, memory-mux, write-mem and write-mem-enable controls.
- reg_dest_in  in  REG_ADDR_WIDTH  destination register.
- alu_result_in  in  DATA_WIDTH  ALU output.
- store_data_in  in  DATA_WIDTH  data for memory write.
- out_valid  out  1  memory stage entry valid.
- out_ready  in  1  memory stage consumes the entry.
- wbs_out, mm_out, wm_out, wme_out  out  1 each  controls, forced 0 when out_valid=0.
- reg_dest_out  out  REG_ADDR_WIDTH
- alu_result_out  out  DATA_WIDTH
- store_data_out  out  DATA_WIDTH
- fwd_valid  out  1  out_valid & wbs_out.
- fwd_reg  out  REG_ADDR_WIDTH  equals reg_dest_out.
- fwd_data  out  DATA_WIDTH  equals alu_result_out.
- stall_count  out  CNT_WIDTH  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: main entry M drives the outputs; skid entry S. Each has a valid bit plus the full payload. Reset is asynchronous, active-low; there is one clock.
- Reset (rst_n=0): M and S valid=0; all payload regs and stall_count = 0.
  - Outputs during reset: out_valid=0, all controls 0, data 0, fwd_valid=0, in_ready=1.
- in_ready = !S.valid, registered-derived with no combinational path from out_ready. Accept = in_valid & in_ready.
- States (derived from valid bits): EMPTY (M=0,S=0), ONE (M=1,S=0), FULL (M=1,S=1). M=0,S=1 is illegal and never reachable.
- EMPTY: accept -> ONE, M<=input. Otherwise stay.
- ONE:
  - out_ready & accept -> ONE, M<=input.
  - out_ready & !accept -> EMPTY.
  - !out_ready & accept -> FULL, S<=input, M holds.
  - Otherwise hold.
- FULL: in_ready=0, so inputs are ignored. out_ready -> ONE, M<=S, S.valid<=0. Otherwise hold.
- Latency: 1 cycle from accept to out_valid when empty. Throughput is 1 entry/cycle with out_ready held high.
- Ordering: strictly FIFO; S is never bypassed.
- flush: highest priority.
  - Next state is EMPTY regardless of in_valid/out_ready; an entry accepted in the flush cycle is discarded.
  - Payload registers may hold stale values, but controls read 0 via out_valid gating.
  - in_ready=1 in the following cycle.
- Payload of an invalid M: data fields hold their last value; control outputs read 0.
- stall_count: increments when out_valid & !out_ready (flush does not prevent counting in that cycle). Saturates at 2^CNT_WIDTH-1. Cleared only by reset.
- Reset asserted mid-transfer: immediate return to reset values; no partial entry survives.
- No combinational path from in_valid to out_valid or from out_ready to in_ready.

Test Plan:
- Reset then streaming: out_ready=1; send entries A (alu=0x1234, reg=3, wbs=1), B, C on consecutive cycles.
  - Expect out_valid from cycle 1, A/B/C in order one cycle apart.
  - Expect fwd_valid=1, fwd_reg=3, fwd_data=0x1234 with A.
  - Expect stall_count=0.
- Backpressure: out_ready=0 while sending A, B, C.
  - A held in M, B captured in S, in_ready=0 from the next cycle; C must be held by the source.
  - out_ready=1 -> A, then B, then C delivered in order, with no loss or duplication.
- Flush in FULL with in_valid=1 (entry D): next cycle out_valid=0, in_ready=1, wbs_out=mm_out=wm_out=wme_out=0, D never appears.
- Stall counter saturation, CNT_WIDTH=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_count=15 and stays 15.
- Async reset asserted mid-cycle in FULL state -> outputs go to reset values immediately without waiting for clk; in_ready=1 after release.
- Random valid/ready (10k cycles) against a scoreboard -> ordering exact, no drop, and M=0,S=1 never observed.
